// File: rtl/uart_frame_pkg.sv
// Shared types and default sizing for the UART frame echo buffer.
// Optional build macro: FRAME_XOR_EN adds the S_KEY state (XOR key byte).
package uart_frame_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_DEPTH  = 100;
  localparam int DEF_LEN_W  = 8;

  typedef enum logic [2:0] {
    S_IDLE,
`ifdef FRAME_XOR_EN
    S_KEY,
`endif
    S_DATA,
    S_TX_LOAD,
    S_TX_WAIT_HI,
    S_TX_WAIT_LO
  } state_e;

endpackage

// File: rtl/frame_ram.sv
// Payload store: synchronous write, combinational read, DEPTH x DATA_W.
module frame_ram #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 100,
  parameter int ADDR_W = 7
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) mem[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem[raddr_i];

endmodule

// File: rtl/uart_frame_buffer.sv
// Receives a length-prefixed frame from a UART receiver and echoes it to a sender.
// Optional build macro: FRAME_XOR_EN (key byte after length, echoed bytes XORed with it).
module uart_frame_buffer
  import uart_frame_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int LEN_W  = DEF_LEN_W
) (
  input  logic              Clk_100M,
  input  logic              Reset,
  input  logic              Reverse,
  input  logic [DATA_W-1:0] Rx_Data,
  input  logic              Rx_Ready,
  output logic              Rx_Ack,
  output logic [DATA_W-1:0] Tx_Data,
  output logic              Tx_Send,
  input  logic              Tx_Busy,
  output logic              Frame_Err,
  output logic              Overrun,
  output logic [LEN_W-1:0]  Frame_Cnt,
  output logic              Busy
);

  localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  state_e            state_q, state_d;
  logic [LEN_W-1:0]  idx_q, idx_d, len_q, len_d, fcnt_q, fcnt_d;
  logic              rev_q, rev_d, rx_prev_q, ack_q, ack_d;
  logic              tx_send_q, tx_send_d, ferr_q, ferr_d, ovr_q, ovr_d;
  logic [DATA_W-1:0] tx_data_q, tx_data_d, rd_data, key;
  logic [ADDR_W-1:0] rd_addr;
  logic [LEN_W-1:0]  idx_inc;
  logic              accept, we;

`ifdef FRAME_XOR_EN
  logic [DATA_W-1:0] key_q, key_d;
  assign key = key_q;
`else
  assign key = '0;
`endif

  // A byte counts only on the first cycle Rx_Ready is seen high.
  assign accept  = Rx_Ready & ~rx_prev_q;
  assign idx_inc = idx_q + LEN_W'(1);
  assign rd_addr = rev_q ? (len_q[ADDR_W-1:0] - ADDR_W'(1) - idx_q[ADDR_W-1:0])
                         : idx_q[ADDR_W-1:0];

  frame_ram #(
    .DATA_W(DATA_W),
    .DEPTH (DEPTH),
    .ADDR_W(ADDR_W)
  ) u_ram (
    .clk_i  (Clk_100M),
    .we_i   (we),
    .waddr_i(idx_q[ADDR_W-1:0]),
    .wdata_i(Rx_Data),
    .raddr_i(rd_addr),
    .rdata_o(rd_data)
  );

  always_ff @(posedge Clk_100M or posedge Reset) begin
    if (Reset) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      len_q     <= '0;
      rev_q     <= 1'b0;
      rx_prev_q <= 1'b0;
      ack_q     <= 1'b0;
      tx_data_q <= '0;
      tx_send_q <= 1'b0;
      ferr_q    <= 1'b0;
      ovr_q     <= 1'b0;
      fcnt_q    <= '0;
`ifdef FRAME_XOR_EN
      key_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      len_q     <= len_d;
      rev_q     <= rev_d;
      rx_prev_q <= Rx_Ready;
      ack_q     <= ack_d;
      tx_data_q <= tx_data_d;
      tx_send_q <= tx_send_d;
      ferr_q    <= ferr_d;
      ovr_q     <= ovr_d;
      fcnt_q    <= fcnt_d;
`ifdef FRAME_XOR_EN
      key_q     <= key_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    len_d     = len_q;
    rev_d     = rev_q;
    tx_data_d = tx_data_q;
    tx_send_d = 1'b0;
    ferr_d    = 1'b0;
    ovr_d     = 1'b0;
    fcnt_d    = fcnt_q;
    we        = 1'b0;
    ack_d     = accept | (ack_q & Rx_Ready);
`ifdef FRAME_XOR_EN
    key_d     = key_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (Rx_Data == '0 || int'(Rx_Data) > DEPTH) begin
            ferr_d = 1'b1;
          end else begin
            len_d = LEN_W'(Rx_Data);
            rev_d = Reverse;
            idx_d = '0;
`ifdef FRAME_XOR_EN
            state_d = S_KEY;
`else
            state_d = S_DATA;
`endif
          end
        end
      end
`ifdef FRAME_XOR_EN
      S_KEY: begin
        if (accept) begin
          key_d   = Rx_Data;
          state_d = S_DATA;
        end
      end
`endif
      S_DATA: begin
        if (accept) begin
          we = 1'b1;
          if (idx_inc == len_q) begin
            idx_d   = '0;
            state_d = S_TX_LOAD;
          end else begin
            idx_d = idx_inc;
          end
        end
      end
      S_TX_LOAD: begin
        if (!Tx_Busy) begin
          tx_data_d = rd_data ^ key;
          tx_send_d = 1'b1;
          state_d   = S_TX_WAIT_HI;
        end
      end
      S_TX_WAIT_HI: begin
        if (Tx_Busy) state_d = S_TX_WAIT_LO;
      end
      S_TX_WAIT_LO: begin
        if (!Tx_Busy) begin
          if (idx_inc == len_q) begin
            idx_d   = '0;
            fcnt_d  = fcnt_q + LEN_W'(1);
            state_d = S_IDLE;
          end else begin
            idx_d   = idx_inc;
            state_d = S_TX_LOAD;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    // Bytes arriving while echoing are acknowledged but dropped.
    if (accept && (state_q == S_TX_LOAD || state_q == S_TX_WAIT_HI ||
                   state_q == S_TX_WAIT_LO))
      ovr_d = 1'b1;
  end

  assign Rx_Ack    = ack_q;
  assign Tx_Data   = tx_data_q;
  assign Tx_Send   = tx_send_q;
  assign Frame_Err = ferr_q;
  assign Overrun   = ovr_q;
  assign Frame_Cnt = fcnt_q;
  assign Busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_frame_buffer.sv
// Directed bench for uart_frame_buffer with a behavioural UART sender responder.
// Define FRAME_XOR_EN on both bench and RTL to exercise the key feature.
module tb_uart_frame_buffer;

  logic       clk = 1'b0;
  logic       rst;
  logic       Reverse;
  logic [7:0] Rx_Data;
  logic       Rx_Ready;
  logic       Rx_Ack;
  logic [7:0] Tx_Data;
  logic       Tx_Send;
  logic       Tx_Busy;
  logic       Frame_Err;
  logic       Overrun;
  logic [7:0] Frame_Cnt;
  logic       Busy;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int n_ovr = 0;
  int n_ferr = 0;
  int first_send_cyc = 0;
  int last_rise_cyc = 0;
  logic [7:0] txq[$];

  uart_frame_buffer #(.DATA_W(8), .DEPTH(100), .LEN_W(8)) dut (
    .Clk_100M (clk),
    .Reset    (rst),
    .Reverse  (Reverse),
    .Rx_Data  (Rx_Data),
    .Rx_Ready (Rx_Ready),
    .Rx_Ack   (Rx_Ack),
    .Tx_Data  (Tx_Data),
    .Tx_Send  (Tx_Send),
    .Tx_Busy  (Tx_Busy),
    .Frame_Err(Frame_Err),
    .Overrun  (Overrun),
    .Frame_Cnt(Frame_Cnt),
    .Busy     (Busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  // Pulse monitors sample mid-cycle
  initial begin
    forever begin
      @(negedge clk);
      if (Overrun) n_ovr++;
      if (Frame_Err) n_ferr++;
    end
  end

  // UART sender model: busy for four cycles after each strobe
  initial begin
    Tx_Busy = 1'b0;
    forever begin
      @(negedge clk);
      if (Tx_Send) begin
        if (txq.size() == 0) first_send_cyc = cyc;
        txq.push_back(Tx_Data);
        Tx_Busy = 1'b1;
        repeat (4) @(negedge clk);
        Tx_Busy = 1'b0;
      end
    end
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic rx_byte(input logic [7:0] b);
    int k;
    @(negedge clk);
    Rx_Data  = b;
    Rx_Ready = 1'b1;
    last_rise_cyc = cyc;
    k = 0;
    while (!Rx_Ack && k < 20) begin
      @(negedge clk);
      k++;
    end
    check_val("rx_ack", {31'b0, Rx_Ack}, 32'd1);
    Rx_Ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while ((Busy || Tx_Busy) && k < 400) begin
      @(negedge clk);
      k++;
    end
    check_val("idle", {31'b0, Busy}, 32'd0);
  endtask

  task automatic new_case();
    txq.delete();
    n_ovr  = 0;
    n_ferr = 0;
  endtask

  initial begin
    rst      = 1'b1;
    Reverse  = 1'b0;
    Rx_Data  = 8'h00;
    Rx_Ready = 1'b0;
    repeat (3) @(negedge clk);
    check_val("rst_busy",    {31'b0, Busy},      32'd0);
    check_val("rst_send",    {31'b0, Tx_Send},   32'd0);
    check_val("rst_txdata",  {24'b0, Tx_Data},   32'd0);
    check_val("rst_fcnt",    {24'b0, Frame_Cnt}, 32'd0);
    check_val("rst_ack",     {31'b0, Rx_Ack},    32'd0);
    check_val("rst_ferr",    {31'b0, Frame_Err}, 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Forward echo
    new_case();
    rx_byte(8'h03); rx_byte("A"); rx_byte("B"); rx_byte("C");
    check_val("fwd_latency", {31'b0, (first_send_cyc - last_rise_cyc) <= 2}, 32'd1);
    wait_idle();
    check_val("fwd_count", txq.size(), 32'd3);
    check_val("fwd_b0", {24'b0, txq[0]}, "A");
    check_val("fwd_b1", {24'b0, txq[1]}, "B");
    check_val("fwd_b2", {24'b0, txq[2]}, "C");
    check_val("fwd_fcnt", {24'b0, Frame_Cnt}, 32'd1);
    check_val("fwd_ovr", n_ovr, 32'd0);

    // Reverse echo; Reverse is dropped after the header to prove it is latched
    new_case();
    Reverse = 1'b1;
    rx_byte(8'h03);
    Reverse = 1'b0;
    rx_byte("A"); rx_byte("B"); rx_byte("C");
    wait_idle();
    check_val("rev_count", txq.size(), 32'd3);
    check_val("rev_b0", {24'b0, txq[0]}, "C");
    check_val("rev_b1", {24'b0, txq[1]}, "B");
    check_val("rev_b2", {24'b0, txq[2]}, "A");
    check_val("rev_fcnt", {24'b0, Frame_Cnt}, 32'd2);

    // Illegal lengths: zero and DEPTH+1
    new_case();
    rx_byte(8'h00);
    rx_byte(8'h65);
    repeat (10) @(negedge clk);
    check_val("ferr_pulses", n_ferr, 32'd2);
    check_val("ferr_nosend", txq.size(), 32'd0);
    check_val("ferr_busy", {31'b0, Busy}, 32'd0);
    check_val("ferr_fcnt", {24'b0, Frame_Cnt}, 32'd2);

    // Extra byte while echoing
    new_case();
    rx_byte(8'h02); rx_byte("x"); rx_byte("y");
    rx_byte(8'h55);
    wait_idle();
    check_val("ovr_count", txq.size(), 32'd2);
    check_val("ovr_b0", {24'b0, txq[0]}, "x");
    check_val("ovr_b1", {24'b0, txq[1]}, "y");
    check_val("ovr_pulses", n_ovr, 32'd1);
    check_val("ovr_fcnt", {24'b0, Frame_Cnt}, 32'd3);

`ifdef FRAME_XOR_EN
    new_case();
    rx_byte(8'h02); rx_byte(8'h20); rx_byte("a"); rx_byte("B");
    wait_idle();
    check_val("xor_count", txq.size(), 32'd2);
    check_val("xor_b0", {24'b0, txq[0]}, "A");
    check_val("xor_b1", {24'b0, txq[1]}, "b");
`endif

    // Reset mid-frame, then a fresh one-byte frame
    new_case();
    rx_byte(8'h05); rx_byte(8'h11); rx_byte(8'h22);
    rst = 1'b1;
    #1;
    check_val("midrst_busy", {31'b0, Busy}, 32'd0);
    check_val("midrst_fcnt", {24'b0, Frame_Cnt}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (30) @(negedge clk);
    check_val("midrst_nosend", txq.size(), 32'd0);
    rx_byte(8'h01); rx_byte("Z");
    wait_idle();
    check_val("post_count", txq.size(), 32'd1);
    check_val("post_b0", {24'b0, txq[0]}, "Z");
    check_val("post_fcnt", {24'b0, Frame_Cnt}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/uart_frame_buffer.md
UART_FRAME_BUFFER -- requirements
Module: uart_frame_buffer

Interface
REQ-001 Parameter DATA_W, default 8: UART character width in bits.
REQ-002 Parameter DEPTH, default 100: maximum payload bytes per frame.
REQ-003 Parameter LEN_W, default 8: width of the length header and byte counters; 2**LEN_W-1 SHALL be >= DEPTH.
REQ-004 Clk_100M  in  1  system clock; all state SHALL be updated on its rising edge.
REQ-005 Reset  in  1  asynchronous, active-high; SHALL clear all state immediately when asserted.
REQ-006 Reverse  in  1  sampled at frame start; 1 = echo the payload last-byte-first.
REQ-007 Rx_Data  in  DATA_W  byte from UART_Receiver.
REQ-008 Rx_Ready  in  1  UART_Receiver has a byte.
REQ-009 Rx_Ack  out  1  acknowledge to UART_Receiver.
REQ-010 Tx_Data  out  DATA_W  byte to UART_Sender.
REQ-011 Tx_Send  out  1  one-cycle send strobe.
REQ-012 Tx_Busy  in  1  UART_Sender is transmitting.
REQ-013 Frame_Err  out  1  one-cycle pulse when a frame is rejected.
REQ-014 Overrun  out  1  one-cycle pulse when a byte is dropped during echo.
REQ-015 Frame_Cnt  out  LEN_W  count of completed echoed frames; wraps modulo 2**LEN_W.
REQ-016 Busy  out  1  high in every state except S_IDLE.

Function
REQ-017 Rx byte accepted only on a Rx_Ready rising edge (previous-cycle value low, current high); Rx_Ack SHALL be set the cycle after acceptance and held until Rx_Ready is low.
REQ-018 States: S_IDLE, S_KEY, S_DATA, S_TX_LOAD, S_TX_WAIT_HI, S_TX_WAIT_LO.
REQ-019 S_IDLE: accepted byte = length L, latched together with Reverse; L==0 or L>DEPTH -> Frame_Err pulse, stay S_IDLE; otherwise -> S_KEY when FRAME_XOR_EN is defined, else S_DATA.
REQ-020 S_DATA: each accepted byte written to buffer[idx], idx incremented; after byte L -> S_TX_LOAD with idx=0.
REQ-021 S_TX_LOAD: when Tx_Busy==0, drive Tx_Data = buffer[Reverse ? L-1-idx : idx], pulse Tx_Send for exactly one cycle -> S_TX_WAIT_HI.
REQ-022 S_TX_WAIT_HI: wait for Tx_Busy==1 -> S_TX_WAIT_LO; S_TX_WAIT_LO: on Tx_Busy==0, idx+1; if idx+1==L -> S_IDLE and Frame_Cnt+1, else -> S_TX_LOAD.
REQ-023 Rx bytes accepted in any S_TX_* state SHALL still be acked, discarded, and flagged by one Overrun pulse each.
REQ-024 Tx_Data SHALL hold its value between sends; latency from the last payload byte's accept to its Tx_Send SHALL be <= 2 cycles when Tx_Busy is low.

Reset
REQ-025 On Reset: state S_IDLE, idx=0, L=0, Rx_Ack=0, Tx_Send=0, Tx_Data=0, Frame_Err=0, Overrun=0, Frame_Cnt=0, Busy=0, previous-Rx_Ready register=0; buffer contents need not be cleared.
REQ-026 Reset asserted mid-frame SHALL abandon the frame; no Tx_Send SHALL be issued after Reset is deasserted until a new frame is fully received.

Configuration
REQ-027 Macro FRAME_XOR_EN defined: S_KEY present; the byte after the length is latched as key K; every transmitted byte is buffer byte XOR K.
REQ-028 FRAME_XOR_EN undefined: no S_KEY and no key register; bytes are echoed unmodified.

Structure
REQ-029 Package uart_frame_pkg SHALL hold the state enumeration typedef and the default DEPTH/DATA_W constants.
REQ-030 Payload storage SHALL be a sub-module frame_ram: one synchronous write port and one read port, DEPTH x DATA_W.

Verification
REQ-031 Rx 0x03,'A','B','C', Reverse=0 -> Tx 'A','B','C', one Tx_Send per byte, Frame_Cnt=1.
REQ-032 Rx 0x03,'A','B','C', Reverse=1 -> Tx 'C','B','A'.
REQ-033 Rx 0x00, then Rx 0x65 (DEPTH=100) -> Frame_Err pulses twice, no Tx_Send, state S_IDLE.
REQ-034 Rx 0x02,'x','y', and one extra byte during echo -> Tx 'x','y', one Overrun pulse.
REQ-035 FRAME_XOR_EN defined: Rx 0x02,0x20,'a','B' -> Tx 'A','b'.
REQ-036 Reset after 2 of 5 payload bytes, then Rx 0x01,'Z' -> Tx only 'Z', Frame_Cnt=1.
